// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-N up/down counter built from JK stages with J/K steering
//   CLK   rising-edge clock        RESET async active-low clear
//   EN    count enable             UP    1 = up, 0 = down
//   LOAD  sync parallel load       D     load value
//   Q/Qinv count and complement    TC    terminal count (comb)
//   J/K   steering presented to the JK stages (debug)
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qinv,
  output logic             TC,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d, tgt;
  // Any out-of-range state steers to 0 (up) or N-1 (down), so the count recovers in one edge.
  always_comb begin
    tgt = UP ? ((q_q >= TOP) ? '0 : q_q + 1'b1)
             : ((q_q == '0 || q_q > TOP) ? TOP : q_q - 1'b1);
    J = !RESET ? '0 : LOAD ? D  : EN ? q_q ^ tgt : '0;
    K = !RESET ? '0 : LOAD ? ~D : EN ? q_q ^ tgt : '0;
    TC = RESET & ~LOAD & EN & ((UP & (q_q == TOP)) | (~UP & (q_q == '0)));
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign q_d[i] = (J[i] & ~q_q[i]) | (~K[i] & q_q[i]);
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) q_q <= '0;
    else        q_q <= q_d;
  assign Q    = q_q;
  assign Qinv = ~q_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: table-driven bench with a next-state scoreboard for jk_mod_counter
module tb_jk_mod_counter;
  logic CLK = 1'b0, RESET = 1'b1, EN = 1'b0, UP = 1'b1, LOAD = 1'b0;
  logic [3:0] D = '0;
  logic [3:0] Q, Qinv, J, K;
  logic TC;
  int checks = 0, errors = 0;
  typedef struct {
    logic r, e, u, l;
    logic [3:0] d, q;
    logic tc;
    logic [3:0] j, k, nq;
  } vec_t;
  vec_t v[$];
  logic [3:0] sb[$];
  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
    .Q(Q), .Qinv(Qinv), .TC(TC), .J(J), .K(K)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic add(input logic r, e, u, l, input logic [3:0] d, q, input logic tc,
                     input logic [3:0] j, k, nq);
    vec_t x;
    x.r = r; x.e = e; x.u = u; x.l = l; x.d = d; x.q = q; x.tc = tc;
    x.j = j; x.k = k; x.nq = nq;
    v.push_back(x);
  endtask
  always @(posedge CLK) begin
    #1;
    if (sb.size() != 0) chk("q_after_edge", Q, sb.pop_front());
  end
  initial begin
    for (int i = 0; i < 3; i++) add(0,1,1,0,4'd0, 4'd0,0,4'h0,4'h0, 4'd0);
    add(1,1,1,0,4'd0, 4'd0,0,4'h1,4'h1, 4'd1);
    add(1,1,1,0,4'd0, 4'd1,0,4'h3,4'h3, 4'd2);
    add(1,1,1,0,4'd0, 4'd2,0,4'h1,4'h1, 4'd3);
    add(1,1,1,0,4'd0, 4'd3,0,4'h7,4'h7, 4'd4);
    add(1,1,1,0,4'd0, 4'd4,0,4'h1,4'h1, 4'd5);
    add(1,1,1,0,4'd0, 4'd5,0,4'h3,4'h3, 4'd6);
    add(1,1,1,0,4'd0, 4'd6,0,4'h1,4'h1, 4'd7);
    add(1,1,1,0,4'd0, 4'd7,0,4'hF,4'hF, 4'd8);
    add(1,1,1,0,4'd0, 4'd8,0,4'h1,4'h1, 4'd9);
    add(1,1,1,0,4'd0, 4'd9,1,4'h9,4'h9, 4'd0);
    add(1,1,1,1,4'd2, 4'd0,0,4'h2,4'hD, 4'd2);
    add(1,1,0,0,4'd0, 4'd2,0,4'h3,4'h3, 4'd1);
    add(1,1,0,0,4'd0, 4'd1,0,4'h1,4'h1, 4'd0);
    add(1,1,0,0,4'd0, 4'd0,1,4'h9,4'h9, 4'd9);
    add(1,1,0,0,4'd0, 4'd9,0,4'h1,4'h1, 4'd8);
    add(1,0,1,1,4'd9, 4'd8,0,4'h9,4'h6, 4'd9);
    add(1,1,1,1,4'd4, 4'd9,0,4'h4,4'hB, 4'd4);
    add(1,0,1,1,4'd13,4'd4,0,4'hD,4'h2, 4'd13);
    for (int i = 0; i < 5; i++) add(1,0,i[0],0,4'd0, 4'd13,0,4'h0,4'h0, 4'd13);
    add(1,1,1,0,4'd0, 4'd13,0,4'hD,4'hD, 4'd0);
    add(1,0,0,1,4'd13,4'd0,0,4'hD,4'h2, 4'd13);
    add(1,1,0,0,4'd0, 4'd13,0,4'h4,4'h4, 4'd9);
    add(1,0,1,1,4'd6, 4'd9,0,4'h6,4'h9, 4'd6);
    #1 RESET = 1'b0;
    foreach (v[n]) begin
      @(negedge CLK);
      RESET = v[n].r; EN = v[n].e; UP = v[n].u; LOAD = v[n].l; D = v[n].d;
      #1;
      chk("q", Q, v[n].q);
      chk("qinv", Qinv, ~v[n].q);
      chk("tc", {3'b0, TC}, {3'b0, v[n].tc});
      chk("j", J, v[n].j);
      chk("k", K, v[n].k);
      sb.push_back(v[n].nq);
    end
    // Async reset between edges at Q=6, with a down count pending so TC would show if ungated.
    @(negedge CLK);
    EN = 1'b1; UP = 1'b0; LOAD = 1'b0;
    #1 chk("pre_reset_q", Q, 4'd6);
    #1 RESET = 1'b0;
    #1;
    chk("async_q", Q, 4'd0);
    chk("async_qinv", Qinv, 4'hF);
    chk("async_tc", {3'b0, TC}, 4'h0);
    chk("async_j", J, 4'h0);
    chk("async_k", K, 4'h0);
    @(posedge CLK);
    #1 chk("held_in_reset", Q, 4'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("release_tc", {3'b0, TC}, 4'h1);
    chk("release_j", J, 4'h9);
    sb.push_back(4'd9);
    @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    chk("sb_drained", 4'(sb.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
